// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Combinational stage enables/flushes from the current state and hazard inputs, plus the
// data-memory valid/ready handshake, halt/fault states and stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             dmem_req,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt, StFault} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [WaitW-1:0] wait_inc;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             active, frozen, eval_hazards, load_use;

  assign wait_inc  = wait_q + WaitW'(1);
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd)));

  // Next-state and stage-control outputs; memory freeze dominates, then redirect, load-use, fetch.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pc_en        = 1'b1;
    pc_sel       = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    dmem_req     = 1'b0;
    halted       = 1'b0;
    bus_error    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    active       = 1'b0;
    frozen       = 1'b0;
    eval_hazards = 1'b0;

    unique case (state_q)
      StRun: begin
        active = 1'b1;
        if (mem_access) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            frozen  = 1'b1;
            state_d = StMemWait;
            wait_d  = '0;
          end
        end
        eval_hazards = !frozen;
        // The WB instruction retires even in a freeze cycle, since MEM/WB is only flushed behind it
        if (wb_halt) state_d = StHalt;
      end
      StMemWait: begin
        active   = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ready) begin
          eval_hazards = 1'b1;
          state_d      = wb_halt ? StHalt : StRun;
          wait_d       = '0;
        end else begin
          frozen = 1'b1;
          wait_d = wait_inc;
          if (wait_inc == WaitMax) state_d = StFault;
        end
      end
      StHalt, StFault: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        halted    = (state_q == StHalt);
        bus_error = (state_q == StFault);
      end
      default: state_d = StRun;
    endcase

    if (frozen) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (eval_hazards) begin
      if (ex_redirect) begin
        // The ID instruction is squashed, so a load-use or fetch stall on it is moot
        pc_sel      = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end

    stall_inc = active && !pc_en;

    if (reset) begin
      state_d      = StRun;
      wait_d       = '0;
      pc_en        = 1'b1;
      pc_sel       = 1'b0;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_flush = 1'b1;
      dmem_req     = 1'b0;
      halted       = 1'b0;
      bus_error    = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  // State, wait counter and performance counters; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_inc) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc) flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed expectations into a
// queue, and a monitor pops and compares against the DUT outputs every cycle at the falling edge.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 32;

  // Control vector order:
  // {pc_en,pc_sel,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_flush,dmem_req,
  //  halted,bus_error}
  localparam logic [10:0] VRun    = 11'b1_0_1_0_1_0_1_0_0_0_0;
  localparam logic [10:0] VReqOk  = 11'b1_0_1_0_1_0_1_0_1_0_0;
  localparam logic [10:0] VRst    = 11'b1_0_1_1_1_1_1_1_0_0_0;
  localparam logic [10:0] VLdUse  = 11'b0_0_0_0_1_1_1_0_0_0_0;
  localparam logic [10:0] VRedir  = 11'b1_1_1_1_1_1_1_0_0_0_0;
  localparam logic [10:0] VRedirR = 11'b1_1_1_1_1_1_1_0_1_0_0;
  localparam logic [10:0] VFetchW = 11'b0_0_1_1_1_0_1_0_0_0_0;
  localparam logic [10:0] VFreeze = 11'b0_0_0_0_0_0_0_1_1_0_0;
  localparam logic [10:0] VHalt   = 11'b0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] VFault  = 11'b0_0_0_0_0_0_0_0_0_0_1;

  typedef struct packed {
    logic [10:0]      ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [7:0]       id;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic             mem_access, dmem_ready, imem_ready, wb_halt;
  logic             pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_en, mem_wb_flush, dmem_req, halted, bus_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_access   (mem_access),
    .dmem_ready   (dmem_ready),
    .imem_ready   (imem_ready),
    .wb_halt      (wb_halt),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_flush (mem_wb_flush),
    .dmem_req     (dmem_req),
    .halted       (halted),
    .bus_error    (bus_error),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every cycle presents a response to compare.
  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
               mem_wb_flush, dmem_req, halted, bus_error};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL ctl step=%0d got=%b want=%b", e.id, act, e.ctl);
        end
        checks++;
        if (stall_cnt !== e.stall) begin
          failures++;
          $display("FAIL stall_cnt step=%0d got=%0d want=%0d", e.id, stall_cnt, e.stall);
        end
        checks++;
        if (flush_cnt !== e.flush) begin
          failures++;
          $display("FAIL flush_cnt step=%0d got=%0d want=%0d", e.id, flush_cnt, e.flush);
        end
      end
    end
  end

  int step_no = 0;

  // Apply one cycle of inputs and queue the expected response for that cycle.
  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                      input logic redir, input logic macc, input logic dready,
                      input logic iready, input logic halt, input logic [10:0] ctl,
                      input int stall, input int flush);
    exp_t e;
    reset       = rst;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    ex_rd       = rd;
    ex_mem_read = mr;
    ex_redirect = redir;
    mem_access  = macc;
    dmem_ready  = dready;
    imem_ready  = iready;
    wb_halt     = halt;
    step_no++;
    e.ctl   = ctl;
    e.stall = CNT_W'(stall);
    e.flush = CNT_W'(flush);
    e.id    = 8'(step_no);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [10:0] ctl, input int stall, input int flush);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
         ctl, stall, flush);
  endtask

  task automatic mem(input logic dready, input logic redir, input logic halt,
                     input logic [10:0] ctl, input int stall, input int flush);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, redir, 1'b1, dready, 1'b1, halt,
         ctl, stall, flush);
  endtask

  initial begin
    // Unchecked first reset cycle so the counters are defined before checking starts.
    reset = 1'b1; id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_mem_read = 0; ex_redirect = 0; mem_access = 0; dmem_ready = 0;
    imem_ready = 1; wb_halt = 0;
    @(posedge clk);
    #1;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, VRst, 0, 0);          // 1 reset outputs
    idle(VRun, 0, 0);                                               // 2 defaults
    step(0, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, 1, 0, VLdUse, 0, 0);// 3 lw x5 / add rs2=x5
    idle(VRun, 1, 0);                                               // 4 single bubble
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 1, 0, VRun, 1, 0);  // 5 rd=x0: no hazard
    step(0, 5'd5, 5'd2, 0, 1, 5'd5, 1, 0, 0, 0, 1, 0, VRun, 1, 0);  // 6 rs1 match unused
    step(0, 5'd7, 5'd2, 1, 0, 5'd7, 1, 0, 0, 0, 1, 0, VLdUse, 1, 0);// 7 rs1 load-use
    step(0, 5'd7, 5'd2, 1, 0, 5'd7, 1, 1, 0, 0, 0, 0, VRedir, 2, 0);// 8 redirect wins all
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, VFetchW, 2, 1);        // 9 fetch wait
    step(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 0, 0, 0, 0, VLdUse, 3, 1);// 10 load-use beats fetch
    mem(1, 0, 0, VReqOk, 4, 1);                                     // 11 zero-wait access
    mem(0, 1, 0, VFreeze, 4, 1);                                    // 12 freeze, redirect held
    mem(0, 1, 0, VFreeze, 5, 1);                                    // 13
    mem(0, 1, 0, VFreeze, 6, 1);                                    // 14
    mem(1, 1, 0, VRedirR, 7, 1);                                    // 15 release + redirect
    idle(VRun, 7, 2);                                               // 16 back in RUN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, VRun, 7, 2);           // 17 wb_halt retires
    idle(VHalt, 7, 2);                                              // 18 halted
    step(0, 5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, 0, 0, VHalt, 7, 2); // 19 counters frozen
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, VRst, 7, 2);           // 20 reset from HALT
    idle(VRun, 0, 0);                                               // 21 counters cleared
    mem(0, 0, 0, VFreeze, 0, 0);                                    // 22 enter MEM_WAIT
    mem(0, 0, 0, VFreeze, 1, 0);                                    // 23 wait 1
    mem(0, 0, 0, VFreeze, 2, 0);                                    // 24 wait 2
    mem(0, 0, 0, VFreeze, 3, 0);                                    // 25 wait 3
    mem(0, 0, 0, VFreeze, 4, 0);                                    // 26 wait 4 -> FAULT
    mem(0, 0, 0, VFault, 5, 0);                                     // 27 fault state
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, VRst, 5, 0);           // 28 reset from FAULT
    idle(VRun, 0, 0);                                               // 29
    mem(0, 0, 0, VFreeze, 0, 0);                                    // 30 enter MEM_WAIT
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, VRst, 1, 0);           // 31 reset drops dmem_req
    idle(VRun, 0, 0);                                               // 32
    mem(0, 0, 0, VFreeze, 0, 0);                                    // 33 enter MEM_WAIT
    mem(1, 0, 1, VReqOk, 1, 0);                                     // 34 release + wb_halt
    idle(VHalt, 1, 0);                                              // 35 halted

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
